// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data SRAM arbiter with port-1 lock bursts and read return tagging
module dmem_arbiter #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  input  logic              p1_lock,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_stall
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOCK = 2'd1,
    COOL = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;       // 1 = port 1 was granted most recently
  logic              pend_vld_q, pend_vld_d;
  logic              pend_tag_q, pend_tag_d; // 1 = pending read belongs to port 1
  logic              gnt0, gnt1;

  // Registered arbitration state; reset drops any read in flight
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_q     <= 1'b1;
      pend_vld_q <= 1'b0;
      pend_tag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      pend_vld_q <= pend_vld_d;
      pend_tag_q <= pend_tag_d;
    end
  end

  // Grant selection and lock FSM next state
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (p0_req && p1_req) begin
          gnt0 = last_q;
          gnt1 = ~last_q;
        end else begin
          gnt0 = p0_req;
          gnt1 = p1_req;
        end
        if (gnt1 && p1_lock) begin
          cnt_d   = CNT_ONE;
          state_d = (LOCK_MAX <= 1) ? COOL : LOCK;
        end
      end
      LOCK: begin
        if (p1_req && p1_lock) begin
          gnt1  = 1'b1;
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
          if (cnt_d == CNT_MAX) begin
            state_d = COOL;
          end
        end else begin
          // Lock released this cycle: fall back to fair arbitration and head to COOL
          state_d = COOL;
          if (p0_req && p1_req) begin
            gnt0 = last_q;
            gnt1 = ~last_q;
          end else begin
            gnt0 = p0_req;
            gnt1 = p1_req;
          end
        end
      end
      COOL: begin
        gnt0    = p0_req;
        gnt1    = p1_req & ~p0_req;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Last-grant pointer and pending read tag follow the grant
  always_comb begin
    last_d     = last_q;
    if (gnt1) begin
      last_d = 1'b1;
    end else if (gnt0) begin
      last_d = 1'b0;
    end
    pend_vld_d = (gnt0 & ~p0_we) | (gnt1 & ~p1_we);
    pend_tag_d = gnt1;
  end

  // SRAM request mux: winner's fields, all zero when idle
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    if (gnt0) begin
      mem_addr  = p0_addr;
      mem_wdata = p0_wdata;
      mem_wen   = p0_we;
      mem_ren   = ~p0_we;
    end else if (gnt1) begin
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
      mem_wen   = p1_we;
      mem_ren   = ~p1_we;
    end
  end

  // Read return steering by pending tag
  always_comb begin
    p0_rvalid = pend_vld_q & ~pend_tag_q;
    p1_rvalid = pend_vld_q & pend_tag_q;
    p0_rdata  = p0_rvalid ? mem_rdata : '0;
    p1_rdata  = p1_rvalid ? mem_rdata : '0;
  end

  assign p0_gnt    = gnt0;
  assign p1_gnt    = gnt1;
  assign cpu_stall = p0_req & ~gnt0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;

  typedef struct packed {
    logic        port;
    logic [63:0] data;
  } exp_t;

  logic        clk;
  logic        arst;
  logic        p0_req, p0_we, p1_req, p1_we, p1_lock;
  logic [63:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [63:0] p0_rdata, p1_rdata;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_wen, mem_ren, cpu_stall;

  int          n_checks;
  int          n_fail;
  exp_t        sb[$];
  exp_t        mon_e;
  logic        prev_rd, prev_port;
  logic [63:0] ref_mem[256];
  logic [63:0] sram_wr[256];
  logic        sram_wv[256];

  dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .LOCK_MAX(4)) dut (
    .clk(clk), .arst(arst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .p1_lock(p1_lock),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_ren(mem_ren),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .cpu_stall(cpu_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] init_word(input int idx);
    case (idx)
      8'h10:   return 64'hDEAD;
      8'h08:   return 64'hA;
      8'h18:   return 64'hB;
      default: return 64'h5A5A_0000 + 64'(idx);
    endcase
  endfunction

  // SRAM model: one-cycle read latency, write in the request cycle
  always @(posedge clk) begin
    if (mem_wen) begin
      sram_wr[mem_addr[7:0]] <= mem_wdata;
      sram_wv[mem_addr[7:0]] <= 1'b1;
    end
    if (mem_ren) begin
      mem_rdata <= sram_wv[mem_addr[7:0]] ? sram_wr[mem_addr[7:0]] : init_word(int'(mem_addr[7:0]));
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) sram_wv[i] = 1'b0;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Read returns are popped from the scoreboard as they appear
  always @(negedge clk) begin
    if (p0_rvalid || p1_rvalid) begin
      if (sb.size() == 0) begin
        check_eq("spurious_rvalid", {62'd0, p1_rvalid, p0_rvalid}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("rv_both", {63'd0, p0_rvalid & p1_rvalid}, 64'd0);
        check_eq("rv_port", {63'd0, p1_rvalid}, {63'd0, mon_e.port});
        check_eq("rdata", mon_e.port ? p1_rdata : p0_rdata, mon_e.data);
        check_eq("rdata_other", mon_e.port ? p0_rdata : p1_rdata, 64'd0);
      end
    end
  end

  // One arbitration cycle: inputs already driven, check grants/mux at negedge
  task automatic step(input logic eg0, input logic eg1);
    logic        ew, er;
    logic [63:0] ea, ed;
    @(negedge clk);
    check_eq("p0_gnt", {63'd0, p0_gnt}, {63'd0, eg0});
    check_eq("p1_gnt", {63'd0, p1_gnt}, {63'd0, eg1});
    check_eq("cpu_stall", {63'd0, cpu_stall}, {63'd0, p0_req & ~eg0});
    check_eq("p0_rvalid", {63'd0, p0_rvalid}, {63'd0, prev_rd & ~prev_port});
    check_eq("p1_rvalid", {63'd0, p1_rvalid}, {63'd0, prev_rd & prev_port});
    ew = eg0 ? p0_we : (eg1 ? p1_we : 1'b0);
    er = (eg0 | eg1) & ~ew;
    ea = eg0 ? p0_addr : (eg1 ? p1_addr : 64'd0);
    ed = eg0 ? p0_wdata : (eg1 ? p1_wdata : 64'd0);
    check_eq("mem_wen", {63'd0, mem_wen}, {63'd0, ew});
    check_eq("mem_ren", {63'd0, mem_ren}, {63'd0, er});
    check_eq("mem_addr", mem_addr, ea);
    check_eq("mem_wdata", mem_wdata, ed);
    if (er) sb.push_back('{port: eg1, data: ref_mem[ea[7:0]]});
    if (ew) ref_mem[ea[7:0]] = ed;
    prev_rd   = er;
    prev_port = eg1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_fail = 0;
    prev_rd = 1'b0; prev_port = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    arst = 1'b1;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0; p1_lock = 0;
    #1;
    check_eq("rst_p0_rvalid", {63'd0, p0_rvalid}, 64'd0);
    check_eq("rst_p1_rvalid", {63'd0, p1_rvalid}, 64'd0);
    check_eq("rst_mem_ren", {63'd0, mem_ren}, 64'd0);
    p0_req = 1; p0_addr = 64'h10;
    #1;
    check_eq("rst_comb_gnt", {63'd0, p0_gnt}, 64'd1);
    check_eq("rst_comb_addr", mem_addr, 64'h10);
    p0_req = 0;
    @(posedge clk); @(posedge clk); #1;
    arst = 1'b0;

    // Conflict after reset: alternating reads, p0 first
    p0_req = 1; p0_addr = 64'h08; p1_req = 1; p1_addr = 64'h18;
    step(1, 0); step(0, 1); step(1, 0); step(0, 1);
    p0_req = 0; p1_req = 0;
    step(0, 0);

    // Single-port read
    p0_req = 1; p0_addr = 64'h10;
    step(1, 0);
    p0_req = 0;
    step(0, 0);

    // Write then read-back on port 1
    p1_req = 1; p1_we = 1; p1_addr = 64'h20; p1_wdata = 64'h55;
    step(0, 1);
    p1_we = 0; p1_wdata = 0;
    step(0, 1);
    p1_req = 0;
    step(0, 0);

    // Full lock burst: four p1 grants, COOL to p0, then alternation
    p0_req = 1; p0_addr = 64'h10; p1_req = 1; p1_addr = 64'h18; p1_lock = 1;
    step(1, 0);
    step(0, 1); step(0, 1); step(0, 1); step(0, 1);
    p1_lock = 0;
    step(1, 0);
    step(0, 1); step(1, 0);

    // Early lock drop after two locked grants
    p1_lock = 1;
    step(0, 1); step(0, 1);
    p1_lock = 0;
    step(1, 0);
    step(1, 0);
    step(0, 1);
    p0_req = 0; p1_req = 0;
    step(0, 0);

    // Asynchronous reset kills a visible read return immediately
    p0_req = 1; p0_addr = 64'h10;
    step(1, 0);
    p0_req = 0;
    check_eq("rvalid_before_rst", {63'd0, p0_rvalid}, 64'd1);
    #1 arst = 1'b1;
    #1 check_eq("async_rst_rvalid", {63'd0, p0_rvalid}, 64'd0);
    sb.delete();
    prev_rd = 1'b0;
    @(posedge clk); #1;
    arst = 1'b0;

    // Reset in the grant cycle of a port-1 read
    p1_req = 1; p1_addr = 64'h18;
    @(negedge clk);
    check_eq("p1_gnt_pre_rst", {63'd0, p1_gnt}, 64'd1);
    arst = 1'b1;
    @(posedge clk); #1;
    check_eq("p1_rvalid_rst", {63'd0, p1_rvalid}, 64'd0);
    arst = 1'b0;
    p0_req = 1; p0_addr = 64'h10;
    step(1, 0);
    p0_req = 0; p1_req = 0;
    step(0, 0);
    step(0, 0);

    check_eq("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
